// File: rtl/bus_pkg.sv
// Shared serial-bus definitions: access modes, slave FSM state encodings, default widths.
package bus_pkg;

  localparam int unsigned DEF_ADDR_WIDTH = 12;
  localparam int unsigned DEF_DATA_WIDTH = 8;

  localparam logic MODE_READ  = 1'b0;
  localparam logic MODE_WRITE = 1'b1;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StAddr  = 3'd1,
    StWdata = 3'd2,
    StPar   = 3'd3,
    StWrite = 3'd4,
    StRead  = 3'd5,
    StRdata = 3'd6
  } slave_state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/slave_mem.sv
// Synchronous single-port RAM behind the serial slave: one-cycle read latency, no array reset.
module slave_mem #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MEM_DEPTH  = 4096
) (
  input  logic                         clk_i,
  input  logic                         we_i,
  input  logic [$clog2(MEM_DEPTH)-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0]        wdata_i,
  output logic [DATA_WIDTH-1:0]        rdata_o
);

  logic [DATA_WIDTH-1:0] memory [0:MEM_DEPTH-1];

  // Write on we_i; registered read of the addressed word every cycle.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      memory[addr_i] <= wdata_i;
    end
    rdata_o <= memory[addr_i];
  end

endmodule

// File: rtl/serial_slave.sv
// Serial bus slave: deserialises mode/address/write data from mwdata (LSB first), accesses the
// local RAM (instance sm) and serialises read data on srdata.
// Optional frame parity check: define SERIAL_SLAVE_PARITY_EN.
module serial_slave
  import bus_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned MEM_DEPTH  = 4096
) (
  input  logic clk,
  input  logic rstn,
  input  logic mvalid,
  input  logic mmode,
  input  logic mwdata,
  output logic srdata,
  output logic srvalid,
  output logic sready,
  output logic serr
);

  localparam int unsigned IdxW = $clog2(MEM_DEPTH);
  localparam int unsigned CntW = $clog2(max_u(ADDR_WIDTH, DATA_WIDTH) + 1);
  localparam logic [CntW-1:0] AddrLast = CntW'(ADDR_WIDTH - 1);
  localparam logic [CntW-1:0] DataLast = CntW'(DATA_WIDTH - 1);

`ifdef SERIAL_SLAVE_PARITY_EN
  localparam slave_state_e AfterRdAddr = StPar;
  localparam slave_state_e AfterWdata  = StPar;
`else
  localparam slave_state_e AfterRdAddr = StRead;
  localparam slave_state_e AfterWdata  = StWrite;
`endif

  slave_state_e          state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  mode_q, mode_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  mem_we;
  logic [IdxW-1:0]       mem_addr;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // Frame bits arrive LSB first, so shifting in from the top leaves bit 0 at index 0.
  logic [ADDR_WIDTH-1:0] addr_shift;
  logic [DATA_WIDTH-1:0] wdata_shift;
  assign addr_shift  = {mwdata, addr_q[ADDR_WIDTH-1:1]};
  assign wdata_shift = {mwdata, wdata_q[DATA_WIDTH-1:1]};

`ifdef SERIAL_SLAVE_PARITY_EN
  logic serr_q, serr_d;
  logic par_exp;
  // wdata is cleared on frame start, so read frames cover only mode and address.
  assign par_exp = ^{mode_q, addr_q, wdata_q};
`endif

  // Next-state, shifters, bit counter and RAM write strobe.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CntW'(1);
    mode_d  = mode_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    shift_d = shift_q;
    mem_we  = 1'b0;
`ifdef SERIAL_SLAVE_PARITY_EN
    serr_d  = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (mvalid) begin
          mode_d  = mmode;
          addr_d  = addr_shift;
          wdata_d = '0;
          cnt_d   = CntW'(1);
          state_d = StAddr;
        end
      end
      StAddr: begin
        if (!mvalid) begin
          state_d = StIdle;
        end else begin
          addr_d = addr_shift;
          if (cnt_q == AddrLast) begin
            state_d = (mode_q == MODE_READ) ? AfterRdAddr : StWdata;
          end
        end
      end
      StWdata: begin
        if (!mvalid) begin
          state_d = StIdle;
        end else begin
          wdata_d = wdata_shift;
          if (cnt_q == DataLast) begin
            state_d = AfterWdata;
          end
        end
      end
`ifdef SERIAL_SLAVE_PARITY_EN
      StPar: begin
        if (!mvalid) begin
          state_d = StIdle;
        end else if (mwdata != par_exp) begin
          serr_d  = 1'b1;
          state_d = StIdle;
        end else begin
          state_d = (mode_q == MODE_WRITE) ? StWrite : StRead;
        end
      end
`endif
      StWrite: begin
        mem_we  = 1'b1;
        state_d = StIdle;
      end
      StRead: begin
        shift_d = mem_rdata;
        state_d = StRdata;
      end
      StRdata: begin
        shift_d = shift_q >> 1;
        if (cnt_q == DataLast) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    // Counter restarts on every state change; entry to StAddr already counts bit 0.
    if ((state_d != state_q) && (state_d != StAddr)) begin
      cnt_d = '0;
    end
  end

  // Protocol state; sm contents are deliberately outside the reset domain.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      mode_q  <= MODE_READ;
      addr_q  <= '0;
      wdata_q <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      shift_q <= shift_d;
    end
  end

`ifdef SERIAL_SLAVE_PARITY_EN
  // One-cycle frame error pulse, visible in the IDLE cycle after a bad PAR bit.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      serr_q <= 1'b0;
    end else begin
      serr_q <= serr_d;
    end
  end
  assign serr = serr_q;
`else
  assign serr = 1'b0;
`endif

  // RAM is addressed from the next-state address so the word is ready during READ.
  assign mem_addr = addr_d[IdxW-1:0];

  slave_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .MEM_DEPTH (MEM_DEPTH)
  ) sm (
    .clk_i  (clk),
    .we_i   (mem_we),
    .addr_i (mem_addr),
    .wdata_i(wdata_q),
    .rdata_o(mem_rdata)
  );

  assign sready  = (state_q == StIdle);
  assign srvalid = (state_q == StRdata);
  assign srdata  = srvalid & shift_q[0];

endmodule

// File: tb/tb_serial_slave.sv
// Bench for serial_slave: a 4K and a 2K slave share the serial master lines.
`timescale 1ns/1ps
module tb_serial_slave;

  localparam int unsigned AW = 12;
  localparam int unsigned DW = 8;
`ifdef SERIAL_SLAVE_PARITY_EN
  localparam int ParBits = 1;
`else
  localparam int ParBits = 0;
`endif

  logic clk = 1'b0;
  logic rstn, mvalid, mmode, mwdata;
  logic srdata_b, srvalid_b, sready_b, serr_b;
  logic srdata_s, srvalid_s, sready_s, serr_s;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  serial_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(4096)) dut_b (
    .clk(clk), .rstn(rstn), .mvalid(mvalid), .mmode(mmode), .mwdata(mwdata),
    .srdata(srdata_b), .srvalid(srvalid_b), .sready(sready_b), .serr(serr_b)
  );

  serial_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(2048)) dut_s (
    .clk(clk), .rstn(rstn), .mvalid(mvalid), .mmode(mmode), .mwdata(mwdata),
    .srdata(srdata_s), .srvalid(srvalid_s), .sready(sready_s), .serr(serr_s)
  );

  typedef struct {
    bit             wr;
    logic [AW-1:0]  addr;
    logic [DW-1:0]  data;
    bit             chk_b;
    bit             chk_s;
    logic [DW-1:0]  exp_b;
    logic [DW-1:0]  exp_s;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (!(sready_b && sready_s) && n < 64) begin
      tick();
      n++;
    end
    check(name, {31'd0, sready_b & sready_s}, 32'd1);
  endtask

  // Drive a frame; stop >= 0 truncates it after that many bits. low counts busy samples.
  task automatic send_frame(input logic mode, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                            input bit bad_par, input int stop, output int low);
    logic [AW+DW:0] bits;
    int n;
    bits = '0;
    for (int i = 0; i < AW; i++) bits[i] = addr[i];
    for (int i = 0; i < DW; i++) bits[AW+i] = data[i];
    n = mode ? AW + DW : AW;
    bits[n] = (^{mode, addr, (mode ? data : 8'h00)}) ^ bad_par;
    n = n + ParBits;
    if (stop >= 0) n = stop;
    low = 0;
    for (int i = 0; i < n; i++) begin
      mvalid = 1'b1;
      mmode  = mode;
      mwdata = bits[i];
      tick();
      if (!sready_b && !sready_s) low++;
    end
    mvalid = 1'b0;
    mmode  = 1'b0;
    mwdata = 1'b0;
  endtask

  task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    int low, cyc;
    logic [10:0] idx_s;
    wait_ready("wr_start_ready");
    send_frame(1'b1, addr, data, 1'b0, -1, low);
    check("wr_frame_busy", low, AW + DW + ParBits);
    cyc = AW + DW + ParBits;
    while (!sready_b && cyc < 64) begin
      tick();
      cyc++;
    end
    // Edges from the first frame bit until sready is seen high again.
    check("wr_busy_cycles", cyc, AW + DW + ParBits + 1);
    check("wr_serr", {30'd0, serr_b, serr_s}, 32'd0);
    idx_s = addr[10:0];
    check("wr_mem_4k", dut_b.sm.memory[addr], data);
    check("wr_mem_2k", dut_s.sm.memory[idx_s], data);
  endtask

  task automatic do_read(input logic [AW-1:0] addr, input bit chk_b, input bit chk_s,
                         input logic [DW-1:0] exp_b, input logic [DW-1:0] exp_s);
    int low, vok;
    logic [DW-1:0] wb, ws;
    wait_ready("rd_start_ready");
    send_frame(1'b0, addr, 8'h00, 1'b0, -1, low);
    check("rd_frame_busy", low, AW + ParBits);
    // READ cycle: no read data yet, still busy.
    check("rd_read_cycle", {29'd0, srvalid_b, srvalid_s, sready_b}, 32'd0);
    tick();
    vok = 0;
    for (int k = 0; k < DW; k++) begin
      if (srvalid_b && srvalid_s && !sready_b) vok++;
      wb[k] = srdata_b;
      ws[k] = srdata_s;
      tick();
    end
    check("rd_srvalid_len", vok, DW);
    check("rd_end_idle", {28'd0, srvalid_b, srdata_b, sready_b, srvalid_s}, 32'h2);
    if (chk_b) check("rd_data_4k", wb, exp_b);
    if (chk_s) check("rd_data_2k", ws, exp_s);
  endtask

  initial begin
    int low;
    vecs[0]  = '{1'b1, 12'h123, 8'hA5, 1'b0, 1'b0, 8'h00, 8'h00};
    vecs[1]  = '{1'b0, 12'h123, 8'h00, 1'b1, 1'b1, 8'hA5, 8'hA5};
    vecs[2]  = '{1'b1, 12'h9AB, 8'h3C, 1'b0, 1'b0, 8'h00, 8'h00};
    vecs[3]  = '{1'b0, 12'h1AB, 8'h00, 1'b0, 1'b1, 8'h00, 8'h3C};
    vecs[4]  = '{1'b0, 12'h9AB, 8'h00, 1'b1, 1'b1, 8'h3C, 8'h3C};
    vecs[5]  = '{1'b1, 12'h000, 8'hFF, 1'b0, 1'b0, 8'h00, 8'h00};
    vecs[6]  = '{1'b0, 12'h000, 8'h00, 1'b1, 1'b1, 8'hFF, 8'hFF};
    vecs[7]  = '{1'b1, 12'hFFF, 8'h01, 1'b0, 1'b0, 8'h00, 8'h00};
    vecs[8]  = '{1'b0, 12'hFFF, 8'h00, 1'b1, 1'b1, 8'h01, 8'h01};
    vecs[9]  = '{1'b1, 12'h7FF, 8'h5A, 1'b0, 1'b0, 8'h00, 8'h00};
    vecs[10] = '{1'b0, 12'hFFF, 8'h00, 1'b1, 1'b1, 8'h01, 8'h5A};
    vecs[11] = '{1'b0, 12'h7FF, 8'h00, 1'b1, 1'b1, 8'h5A, 8'h5A};

    rstn   = 1'b0;
    mvalid = 1'b0;
    mmode  = 1'b0;
    mwdata = 1'b0;
    tick();
    tick();
    check("reset_out_4k", {28'd0, srdata_b, srvalid_b, sready_b, serr_b}, 32'h2);
    check("reset_out_2k", {28'd0, srdata_s, srvalid_s, sready_s, serr_s}, 32'h2);
    rstn = 1'b1;
    tick();

    for (int i = 0; i < 12; i++) begin
      if (vecs[i].wr) do_write(vecs[i].addr, vecs[i].data);
      else do_read(vecs[i].addr, vecs[i].chk_b, vecs[i].chk_s, vecs[i].exp_b, vecs[i].exp_s);
    end

    // Abort after 5 address bits of a write to 0x123.
    send_frame(1'b1, 12'h123, 8'h00, 1'b0, 5, low);
    tick();
    check("abort_addr_idle", {30'd0, sready_b, serr_b}, 32'h2);
    tick();
    tick();
    check("abort_addr_mem", dut_b.sm.memory[12'h123], 8'hA5);

    // Abort three bits into the write data.
    send_frame(1'b1, 12'h123, 8'h00, 1'b0, AW + 3, low);
    tick();
    check("abort_data_idle", {30'd0, sready_b, serr_b}, 32'h2);
    tick();
    tick();
    check("abort_data_mem", dut_b.sm.memory[12'h123], 8'hA5);

    // Reset while RDATA bit 3 is on the line.
    wait_ready("rst_start_ready");
    send_frame(1'b0, 12'h123, 8'h00, 1'b0, -1, low);
    tick();
    tick();
    tick();
    tick();
    check("rst_pre_bit3", {30'd0, srvalid_b, srdata_b}, 32'h2);
    rstn = 1'b0;
    #1;
    check("rst_async_out", {29'd0, srvalid_b, sready_b, srdata_b}, 32'h2);
    tick();
    tick();
    rstn = 1'b1;
    tick();
    do_read(12'h123, 1'b1, 1'b1, 8'hA5, 8'hA5);

`ifdef SERIAL_SLAVE_PARITY_EN
    // Bad parity on a write: one-cycle serr, no update.
    wait_ready("par_start_ready");
    send_frame(1'b1, 12'h123, 8'h00, 1'b1, -1, low);
    check("par_wr_serr", {30'd0, serr_b, sready_b}, 32'h3);
    tick();
    check("par_wr_serr_off", {31'd0, serr_b}, 32'd0);
    check("par_wr_mem", dut_b.sm.memory[12'h123], 8'hA5);
    // Bad parity on a read: serr and no response.
    send_frame(1'b0, 12'h123, 8'h00, 1'b1, -1, low);
    check("par_rd_serr", {31'd0, serr_b}, 32'd1);
    low = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (srvalid_b) low++;
    end
    check("par_rd_noresp", low, 0);
    do_write(12'h123, 8'h42);
    do_read(12'h123, 1'b1, 1'b1, 8'h42, 8'h42);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
